// File: rtl/loop_sequencer_pkg.sv
// loop_sequencer_pkg
// Shared definitions for the nested-loop index generator: the FSM state
// encoding and the default index/bound width.
package loop_sequencer_pkg;

  localparam int IDX_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seqState_t;

endpackage

// File: rtl/loop_sequencer_level.sv
// loop_level
// One level of the nested loop: holds the latched trip count and the current
// index. Levels are chained by feeding one level's wrapOut into the next
// outer level's advanceIn.
// Ports:
//   clkIn, rstIn   clock, async active-high reset
//   loadIn         latch boundIn as this level's trip count
//   boundIn        trip count presented on a start
//   clearIn        force the index to 0 (takes priority over advanceIn)
//   advanceIn      step the index by one, wrapping at bound-1
//   idxOut         current index
//   atBoundOut     index equals bound-1
//   wrapOut        strobe: advancing while at bound-1 (carry to outer level)
module loop_level #(
  parameter int W = 8
) (
  input  logic         clkIn,
  input  logic         rstIn,
  input  logic         loadIn,
  input  logic [W-1:0] boundIn,
  input  logic         clearIn,
  input  logic         advanceIn,
  output logic [W-1:0] idxOut,
  output logic         atBoundOut,
  output logic         wrapOut
);

  logic [W-1:0] boundQ, boundD;
  logic [W-1:0] idxQ, idxD;
  logic [W-1:0] boundMinus1;

  // A zero bound never reaches RUN, so the guard only keeps the subtraction
  // from producing an all-ones compare value.
  assign boundMinus1 = (boundQ != '0) ? (boundQ - W'(1)) : '0;
  assign atBoundOut  = (idxQ == boundMinus1);
  assign wrapOut     = advanceIn & atBoundOut;
  assign idxOut      = idxQ;

  always_comb begin
    boundD = boundQ;
    idxD   = idxQ;
    if (loadIn) begin
      boundD = boundIn;
    end
    if (clearIn) begin
      idxD = '0;
    end else if (advanceIn) begin
      idxD = atBoundOut ? '0 : (idxQ + W'(1));
    end
  end

  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      boundQ <= '0;
      idxQ   <= '0;
    end else begin
      boundQ <= boundD;
      idxQ   <= idxD;
    end
  end

endmodule

// File: rtl/loop_sequencer.sv
// loop_sequencer
// Three-level nested-loop index generator. A start latches the trip counts
// (I, J, K) and the block then emits one (i, j, k) tuple per accepted beat
// over valid/ready, k innermost, followed by a one-cycle done pulse.
// Configuration macro: LOOP_SEQ_ABORT_EN adds abortIn, which cancels a run.
// Ports:
//   clkIn, rstIn              clock, async active-high reset
//   startIn                   start request (only honoured in IDLE)
//   dimIIn, dimJIn, dimKIn    trip counts, latched on an accepted start
//   readyIn                   downstream accepts the current beat
//   validOut                  tuple valid
//   iOut, jOut, kOut          current indices
//   lastKOut                  current beat has k == K-1
//   lastOut                   current beat is the final tuple of the run
//   busyOut                   run in progress (RUN or DONE)
//   doneOut                   one-cycle completion pulse
//   abortIn                   (LOOP_SEQ_ABORT_EN only) cancel the run
module loop_sequencer
  import loop_sequencer_pkg::*;
#(
  parameter int IDX_WIDTH = IDX_WIDTH_DEFAULT
) (
  input  logic                 clkIn,
  input  logic                 rstIn,
  input  logic                 startIn,
  input  logic [IDX_WIDTH-1:0] dimIIn,
  input  logic [IDX_WIDTH-1:0] dimJIn,
  input  logic [IDX_WIDTH-1:0] dimKIn,
  input  logic                 readyIn,
`ifdef LOOP_SEQ_ABORT_EN
  input  logic                 abortIn,
`endif
  output logic                 validOut,
  output logic [IDX_WIDTH-1:0] iOut,
  output logic [IDX_WIDTH-1:0] jOut,
  output logic [IDX_WIDTH-1:0] kOut,
  output logic                 lastKOut,
  output logic                 lastOut,
  output logic                 busyOut,
  output logic                 doneOut
);

  seqState_t stateQ, stateD;

  logic abortSig;
  logic validSig;
  logic doneSig;
  logic loadSig;
  logic clearSig;
  logic acceptSig;
  logic anyZero;
  logic kAtBound, jAtBound, iAtBound;
  logic kWrap, jWrap, iWrap;

`ifdef LOOP_SEQ_ABORT_EN
  assign abortSig = abortIn;
`else
  assign abortSig = 1'b0;
`endif

  assign anyZero   = (dimIIn == '0) | (dimJIn == '0) | (dimKIn == '0);
  assign acceptSig = validSig & readyIn;

  // Level chain: k advances on every accepted beat, each wrap carries outward.
  loop_level #(.W(IDX_WIDTH)) uLevelK (
    .clkIn      (clkIn),
    .rstIn      (rstIn),
    .loadIn     (loadSig),
    .boundIn    (dimKIn),
    .clearIn    (clearSig),
    .advanceIn  (acceptSig),
    .idxOut     (kOut),
    .atBoundOut (kAtBound),
    .wrapOut    (kWrap)
  );

  loop_level #(.W(IDX_WIDTH)) uLevelJ (
    .clkIn      (clkIn),
    .rstIn      (rstIn),
    .loadIn     (loadSig),
    .boundIn    (dimJIn),
    .clearIn    (clearSig),
    .advanceIn  (kWrap),
    .idxOut     (jOut),
    .atBoundOut (jAtBound),
    .wrapOut    (jWrap)
  );

  loop_level #(.W(IDX_WIDTH)) uLevelI (
    .clkIn      (clkIn),
    .rstIn      (rstIn),
    .loadIn     (loadSig),
    .boundIn    (dimIIn),
    .clearIn    (clearSig),
    .advanceIn  (jWrap),
    .idxOut     (iOut),
    .atBoundOut (iAtBound),
    .wrapOut    (iWrap)
  );

  // The outermost wrap fires exactly on the accepted final beat, which also
  // leaves every index back at 0 for the next run. Abort wins over that beat.
  always_comb begin
    stateD   = stateQ;
    validSig = 1'b0;
    doneSig  = 1'b0;
    loadSig  = 1'b0;
    clearSig = 1'b0;
    case (stateQ)
      IDLE: begin
        if (startIn) begin
          loadSig  = 1'b1;
          clearSig = 1'b1;
          stateD   = anyZero ? DONE : RUN;
        end
      end
      RUN: begin
        validSig = 1'b1;
        if (abortSig) begin
          clearSig = 1'b1;
          stateD   = IDLE;
        end else if (iWrap) begin
          stateD = DONE;
        end
      end
      DONE: begin
        doneSig = 1'b1;
        stateD  = IDLE;
      end
      default: begin
        stateD = IDLE;
      end
    endcase
  end

  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      stateQ <= IDLE;
    end else begin
      stateQ <= stateD;
    end
  end

  assign validOut = validSig;
  assign doneOut  = doneSig;
  assign busyOut  = (stateQ == RUN) | (stateQ == DONE);
  assign lastKOut = validSig & kAtBound;
  assign lastOut  = validSig & kAtBound & jAtBound & iAtBound;

endmodule

// File: doc/loop_sequencer.md
# loop_sequencer

Three-level nested-loop index generator for the matrix accelerator datapath. On a start command it latches loop bounds (I, J, K) and emits one (i, j, k) index tuple per beat over a valid/ready handshake, k innermost, then reports completion. It is the controlling side of an iteration count: it produces the clear/advance/end-of-count decisions that a plain counter only consumes. It sits between the RISC-V command interface and the operand-fetch/MAC pipeline.

## Interface
- IDX_WIDTH, 8, width of each loop bound and index
- clkIn  input  1  clock, rising edge
- rstIn  input  1  reset, asynchronous, active-high
- startIn  input  1  start request, sampled only in IDLE
- dimIIn / dimJIn / dimKIn  input  IDX_WIDTH each  loop trip counts, latched on accepted start
- readyIn  input  1  downstream accepts current beat
- validOut  output  1  index tuple valid
- iOut / jOut / kOut  output  IDX_WIDTH each  current indices
- lastKOut  output  1  current beat has k == K-1 (accumulator flush)
- lastOut  output  1  current beat is final tuple of the run
- busyOut  output  1  run in progress (RUN or DONE state)
- doneOut  output  1  one-cycle completion pulse
- abortIn  input  1  only when LOOP_SEQ_ABORT_EN defined

## Operation
- States: IDLE, RUN, DONE.
- IDLE: startIn=1 latches dims, clears indices to 0. If any dim is 0, go to DONE; else go to RUN.
- RUN: validOut=1. A beat is accepted when validOut && readyIn.
- On an accepted beat:
  - k increments.
  - If k==K-1, k wraps to 0 and j increments.
  - If j==J-1 at that wrap, j wraps to 0 and i increments.
  - The beat with lastOut=1 moves the FSM to DONE.
- readyIn=0: indices and validOut hold. Tuple must stay stable while not accepted.
- DONE: lasts exactly one cycle. doneOut=1, validOut=0, then IDLE.
- startIn is ignored in RUN and DONE. Dims inputs are don't-care outside the start cycle.
- lastKOut = validOut && (k==K-1). lastOut = validOut && all three indices at bound-1.
- Arithmetic: compare against latched dim-1, computed only for nonzero dims. Indices never exceed dim-1 and never wrap past 2^IDX_WIDTH.
- Maximum run: (2^IDX_WIDTH-1)^3 beats.

## Timing
- Reset (async assert, sync-safe deassert): state IDLE. validOut, busyOut, doneOut, lastKOut, lastOut are 0. iOut, jOut, kOut are 0.
- Start accepted at edge N:
  - validOut=1 with (0,0,0) from cycle N+1.
  - busyOut=1 from cycle N+1.
- Throughput: one tuple per cycle while readyIn=1.
- Final beat accepted at edge M:
  - Cycle M+1: validOut=0, doneOut=1, busyOut=1.
  - Cycle M+2: IDLE, busyOut=0. Earliest new start is sampled at edge M+2.
- Zero-dim start at edge N: doneOut=1 in cycle N+1, no valid beats.
- Reset mid-run: immediate return to IDLE, no doneOut.

## Configuration
- LOOP_SEQ_ABORT_EN defined:
  - Adds abortIn.
  - abortIn=1 in RUN: next cycle goes to IDLE, validOut=0, indices cleared, no doneOut pulse.
  - abortIn has priority over a beat accepted in the same cycle; that beat counts as delivered.
  - abortIn has no effect in IDLE or DONE.
- Not defined: no abortIn port. A run always completes or is reset.

## Structure
- Shared package: FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default IDX_WIDTH constant.
- Sub-module loop_level, instantiated three times and chained by wrap outputs. Each instance holds:
  - the latched bound and index register;
  - clear and advance inputs;
  - an atBound output and a wrap strobe.

## Test plan
- I=2,J=2,K=3, readyIn=1: 12 beats, k cycles 0,1,2. lastKOut on beats 3,6,9,12; lastOut on beat 12 only; doneOut 1 cycle later.
- Same run with readyIn toggling 1,0 every cycle: 12 accepted beats, indices stable while readyIn=0, doneOut after the 12th accept.
- dimJ=0 start: no validOut, doneOut=1 one cycle after start, busyOut high for that cycle only.
- startIn held high through the whole run with I=J=K=1: exactly one beat and one doneOut. A new run starts at the first edge after IDLE returns.
- rstIn pulsed mid-run at beat 5 of 2x2x3: all outputs 0 asynchronously, no doneOut. A fresh start restarts at (0,0,0).
- LOOP_SEQ_ABORT_EN: abortIn at beat 4 with readyIn=1: validOut low next cycle, no doneOut, busyOut low, next start restarts at (0,0,0).
